// File: rtl/multicycle_control_pkg.sv
// multicycle_control shared definitions: opcodes, funct fields,
// ALU encodings, FSM states and the control-word bundles.
package multicycle_control_pkg;

  localparam logic [6:0] OP_ARITH = 7'h33;
  localparam logic [6:0] OP_ADDI  = 7'h13;
  localparam logic [6:0] OP_COND  = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;

  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SLT = 3'd2;
  localparam logic [2:0] F3_XOR = 3'd4;
  localparam logic [2:0] F3_OR  = 3'd6;
  localparam logic [2:0] F3_AND = 3'd7;
  localparam logic [2:0] F3_BEQ = 3'd0;
  localparam logic [2:0] F3_BNE = 3'd1;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;
  localparam logic [2:0] F3_SD  = 3'd3;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_SUB  = 7'h20;

  localparam logic [2:0] ALU_add  = 3'd0;
  localparam logic [2:0] ALU_sub  = 3'd1;
  localparam logic [2:0] ALU_and  = 3'd2;
  localparam logic [2:0] ALU_or   = 3'd3;
  localparam logic [2:0] ALU_xor  = 3'd4;
  localparam logic [2:0] ALU_slt  = 3'd5;
  localparam logic [2:0] ALU_addi = 3'd6;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    K_ARITH,
    K_COND,
    K_JUMP,
    K_LOAD,
    K_STORE
  } kind_e;

  typedef struct packed {
    kind_e      kind;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       bne;
    logic [1:0] memtoreg;
    logic [7:0] wmask;
  } ctrl_t;

  typedef struct packed {
    logic       imem_req;
    logic       pc_wr;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [1:0] memtoreg;
    logic       mem_req;
    logic       mem_wr;
    logic [7:0] wmask;
    logic       bra;
    logic       bne;
    logic       jump;
    logic       reg_wr;
  } out_t;

endpackage

// File: rtl/multicycle_control_instr_decode.sv
// Combinational decode of opcode/funct3/funct7 into a control word.
// STORE_BYTE_EN makes SB a legal store with a single-byte mask.
module multicycle_control_instr_decode
  import multicycle_control_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    unique case (1'b1)
      opcode == OP_ARITH: begin
        ctrl.kind     = K_ARITH;
        ctrl.memtoreg = WB_ALU;
        unique case (funct3)
          F3_ADD:  ctrl.alu_op = (funct7 == F7_SUB) ?
                                 ALU_sub : ALU_add;
          F3_SLT:  ctrl.alu_op = ALU_slt;
          F3_XOR:  ctrl.alu_op = ALU_xor;
          F3_OR:   ctrl.alu_op = ALU_or;
          F3_AND:  ctrl.alu_op = ALU_and;
          default: illegal = 1'b1;
        endcase
      end
      opcode == OP_ADDI: begin
        ctrl.kind    = K_ARITH;
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALU_addi;
      end
      opcode == OP_COND: begin
        ctrl.kind   = K_COND;
        ctrl.alu_op = ALU_sub;
        ctrl.bne    = (funct3 == F3_BNE);
      end
      opcode == OP_JAL,
      opcode == OP_JALR: begin
        ctrl.kind     = K_JUMP;
        ctrl.alu_src  = 1'b1;
        ctrl.alu_op   = ALU_addi;
        ctrl.memtoreg = WB_PC4;
      end
      opcode == OP_LOAD: begin
        ctrl.kind     = K_LOAD;
        ctrl.alu_src  = 1'b1;
        ctrl.alu_op   = ALU_addi;
        ctrl.memtoreg = WB_MEM;
      end
      opcode == OP_STORE: begin
        ctrl.kind    = K_STORE;
        ctrl.alu_src = 1'b1;
        ctrl.alu_op  = ALU_addi;
        unique case (funct3)
          F3_SD: begin
            if (XLEN == 64) ctrl.wmask = 8'hFF;
            else            illegal    = 1'b1;
          end
          F3_SW: ctrl.wmask = 8'h0F;
          F3_SH: ctrl.wmask = 8'h03;
`ifdef STORE_BYTE_EN
          F3_SB: ctrl.wmask = 8'h01;
`endif
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV control FSM: FETCH/DECODE/EXEC/MEM/WB with traps.
// Define STORE_BYTE_EN to accept SB stores (wmask = 1).
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  input  logic              mem_ack,
  input  logic              alu_zero,
  output logic              imem_req,
  output logic              ir_wr,
  output logic              pc_wr,
  output logic              ALUsrc,
  output logic [2:0]        ALUOp,
  output logic [1:0]        memtoreg,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [XLEN/8-1:0] wmask,
  output logic              bra,
  output logic              bne,
  output logic              jump,
  output logic              reg_wr,
  output logic              illegal,
  output logic              fault,
  output logic [2:0]        state
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [16:0]   ir_q, ir_d;
  ctrl_t         ctrl_q, ctrl_d, dec_ctrl;
  out_t          out_q, out_d;
  logic          ill_q, ill_d;
  logic          flt_q, flt_d;
  logic          dec_ill;
  logic          fetch_ack;
  logic          mem_done;
  logic          waiting;
  logic          unused_fields;

  // Register fields are handled by the datapath's own IR.
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  assign fetch_ack = out_q.imem_req & instr_valid;
  assign mem_done  = out_q.mem_req & mem_ack;
  assign waiting   = (state_q == S_FETCH && out_q.imem_req
                      && !instr_valid)
                   || (state_q == S_MEM && !mem_ack);

  multicycle_control_instr_decode #(
    .XLEN(XLEN)
  ) u_dec (
    .opcode (ir_q[6:0]),
    .funct3 (ir_q[9:7]),
    .funct7 (ir_q[16:10]),
    .ctrl   (dec_ctrl),
    .illegal(dec_ill)
  );

  always_comb begin
    state_d = state_q;
    ill_d   = ill_q;
    flt_d   = flt_q;
    ir_d    = ir_q;
    if (fetch_ack) begin
      ir_d = {instr[31:25], instr[14:12], instr[6:0]};
    end
    unique case (state_q)
      S_FETCH: begin
        if (fetch_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec_ill) begin
          state_d = S_TRAP;
          ill_d   = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (ctrl_q.kind)
          K_COND:          state_d = S_FETCH;
          K_LOAD, K_STORE: state_d = S_MEM;
          default:         state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_done) begin
          state_d = (ctrl_q.kind == K_STORE) ?
                    S_FETCH : S_WB;
        end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_TRAP;
    endcase
    // An ack in the limit cycle clears waiting, so it wins.
    if (waiting && cnt_q == CNT_MAX) begin
      state_d = S_TRAP;
      flt_d   = 1'b1;
    end
    cnt_d = (waiting && state_d == state_q) ?
            cnt_q + CW'(1) : '0;
  end

  always_comb begin
    ctrl_d = (state_q == S_DECODE) ? dec_ctrl : ctrl_q;
    out_d  = '0;
    unique case (state_d)
      S_FETCH: out_d.imem_req = 1'b1;
      S_EXEC: begin
        out_d.alu_src = ctrl_d.alu_src;
        out_d.alu_op  = ctrl_d.alu_op;
        out_d.bra     = (ctrl_d.kind == K_COND);
        out_d.bne     = ctrl_d.bne;
        out_d.jump    = (ctrl_d.kind == K_JUMP);
        out_d.pc_wr   = (ctrl_d.kind == K_JUMP);
      end
      S_MEM: begin
        out_d.mem_req = 1'b1;
        out_d.alu_src = 1'b1;
        out_d.alu_op  = ALU_addi;
        out_d.mem_wr  = (ctrl_d.kind == K_STORE);
        out_d.wmask   = ctrl_d.wmask;
      end
      S_WB: begin
        out_d.reg_wr   = 1'b1;
        out_d.memtoreg = ctrl_d.memtoreg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      ir_q    <= '0;
      ctrl_q  <= '0;
      out_q   <= '0;
      ill_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      ctrl_q  <= ctrl_d;
      out_q   <= out_d;
      ill_q   <= ill_d;
      flt_q   <= flt_d;
    end
  end

  // Fetch accept and the branch decision follow their live inputs.
  assign imem_req = out_q.imem_req;
  assign ir_wr    = fetch_ack;
  assign pc_wr    = fetch_ack | out_q.pc_wr
                  | (out_q.bra & (alu_zero ^ out_q.bne));
  assign ALUsrc   = out_q.alu_src;
  assign ALUOp    = out_q.alu_op;
  assign memtoreg = out_q.memtoreg;
  assign mem_req  = out_q.mem_req;
  assign mem_wr   = out_q.mem_wr;
  assign wmask    = out_q.wmask[XLEN/8-1:0];
  assign bra      = out_q.bra;
  assign bne      = out_q.bne;
  assign jump     = out_q.jump;
  assign reg_wr   = out_q.reg_wr;
  assign illegal  = ill_q;
  assign fault    = flt_q;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected
// output vectors queued with stimulus, compared at negedge.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  localparam int XLEN     = 64;
  localparam int WAIT_MAX = 15;

  localparam int T_AR  = 0;
  localparam int T_CND = 1;
  localparam int T_JMP = 2;
  localparam int T_LD  = 3;
  localparam int T_ST  = 4;
  localparam int T_ILL = 5;

  typedef struct packed {
    logic       imem_req;
    logic       ir_wr;
    logic       pc_wr;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [1:0] memtoreg;
    logic       mem_req;
    logic       mem_wr;
    logic [7:0] wmask;
    logic       bra;
    logic       bne;
    logic       jump;
    logic       reg_wr;
    logic       illegal;
    logic       fault;
    logic [2:0] state;
  } obs_t;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] instr;
  logic        instr_valid, mem_ack, alu_zero;
  logic        imem_req, ir_wr, pc_wr, ALUsrc;
  logic [2:0]  ALUOp;
  logic [1:0]  memtoreg;
  logic        mem_req, mem_wr;
  logic [7:0]  wmask;
  logic        bra, bne, jump, reg_wr;
  logic        illegal, fault;
  logic [2:0]  state;

  obs_t  obs;
  obs_t  sb_q[$];
  string tag_q[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    n_ins = 0;

  always #5 clk = ~clk;

  multicycle_control #(
    .XLEN    (XLEN),
    .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .instr      (instr),
    .instr_valid(instr_valid),
    .mem_ack    (mem_ack),
    .alu_zero   (alu_zero),
    .imem_req   (imem_req),
    .ir_wr      (ir_wr),
    .pc_wr      (pc_wr),
    .ALUsrc     (ALUsrc),
    .ALUOp      (ALUOp),
    .memtoreg   (memtoreg),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .wmask      (wmask),
    .bra        (bra),
    .bne        (bne),
    .jump       (jump),
    .reg_wr     (reg_wr),
    .illegal    (illegal),
    .fault      (fault),
    .state      (state)
  );

  assign obs = {imem_req, ir_wr, pc_wr, ALUsrc, ALUOp,
                memtoreg, mem_req, mem_wr, wmask, bra, bne,
                jump, reg_wr, illegal, fault, state};

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      obs_t e;
      e = sb_q.pop_front();
      check(tag_q.pop_front(), 64'(obs), 64'(e));
    end
  end

  function automatic logic [31:0] enc(input logic [6:0] f7,
                                      input logic [2:0] f3,
                                      input logic [6:0] op);
    return {f7, 5'd2, 5'd1, f3, 5'd3, op};
  endfunction

  task automatic cyc(input obs_t e, input logic iv,
                     input logic ack, input logic az);
    @(posedge clk);
    #1;
    instr_valid = iv;
    mem_ack     = ack;
    alu_zero    = az;
    sb_q.push_back(e);
    tag_q.push_back($sformatf("i%0d_s%0d", n_ins, e.state));
  endtask

  task automatic rcyc(input logic r);
    obs_t z;
    z = '0;
    @(posedge clk);
    #1;
    nrst        = r;
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
    alu_zero    = 1'b0;
    sb_q.push_back(z);
    tag_q.push_back($sformatf("rst_i%0d", n_ins));
  endtask

  task automatic do_reset();
    rcyc(1'b0);
    rcyc(1'b0);
    rcyc(1'b1);
  endtask

  task automatic trap(input logic ill, input logic flt);
    obs_t e;
    e = '0;
    e.state   = 3'd7;
    e.illegal = ill;
    e.fault   = flt;
    for (int i = 0; i < 3; i++) cyc(e, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic do_instr(input logic [31:0] iw, input int kind,
                          input logic [2:0] aop, input logic asrc,
                          input logic [7:0] wm, input int fw,
                          input int mw, input logic az,
                          input logic nz, input logic abort);
    obs_t e;
    logic bnef;
    int   n;
    n_ins++;
    instr = iw;
    bnef  = (kind == T_CND) && (iw[14:12] == 3'd1);
    n = (fw > WAIT_MAX) ? WAIT_MAX + 1 : fw;
    e = '0;
    e.imem_req = 1'b1;
    for (int i = 0; i < n; i++) cyc(e, 1'b0, nz, 1'b0);
    if (fw > WAIT_MAX) begin
      trap(1'b0, 1'b1);
      return;
    end
    e.ir_wr = 1'b1;
    e.pc_wr = 1'b1;
    cyc(e, 1'b1, nz, 1'b0);
    e = '0;
    e.state = 3'd1;
    cyc(e, nz, nz, 1'b0);
    if (kind == T_ILL) begin
      trap(1'b1, 1'b0);
      return;
    end
    e = '0;
    e.state   = 3'd2;
    e.alu_src = asrc;
    e.alu_op  = aop;
    e.bra     = (kind == T_CND);
    e.bne     = bnef;
    e.jump    = (kind == T_JMP);
    e.pc_wr   = (kind == T_JMP) || (kind == T_CND && (az ^ bnef));
    cyc(e, nz, nz, az);
    if (kind == T_CND) return;
    if (kind == T_LD || kind == T_ST) begin
      n = (mw > WAIT_MAX) ? WAIT_MAX + 1 : mw;
      e = '0;
      e.state   = 3'd3;
      e.mem_req = 1'b1;
      e.alu_src = 1'b1;
      e.alu_op  = ALU_addi;
      e.mem_wr  = (kind == T_ST);
      e.wmask   = (kind == T_ST) ? wm : 8'h00;
      for (int i = 0; i < n; i++) cyc(e, nz, 1'b0, 1'b0);
      if (mw > WAIT_MAX) begin
        trap(1'b0, 1'b1);
        return;
      end
      cyc(e, nz, 1'b1, 1'b0);
      if (kind == T_ST) return;
    end
    e = '0;
    e.state    = 3'd4;
    e.reg_wr   = 1'b1;
    e.memtoreg = (kind == T_LD)  ? 2'b01 :
                 (kind == T_JMP) ? 2'b10 : 2'b00;
    cyc(e, nz, nz, 1'b0);
    if (abort) begin
      #5;
      nrst = 1'b0;
      #1;
      check("abort_reg_wr", 64'(reg_wr), 64'd0);
      check("abort_state", 64'(state), 64'd0);
    end
  endtask

  initial begin
    nrst        = 1'b0;
    instr       = '0;
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
    alu_zero    = 1'b0;
    do_reset();
    do_instr(enc(7'h20, 3'd0, 7'h33), T_AR, ALU_sub, 1'b0,
             8'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    do_instr(enc(7'h00, 3'd0, 7'h33), T_AR, ALU_add, 1'b0,
             8'h00, 2, 0, 1'b0, 1'b1, 1'b0);
    do_instr(enc(7'h00, 3'd4, 7'h33), T_AR, ALU_xor, 1'b0,
             8'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    do_instr(enc(7'h01, 3'd0, 7'h13), T_AR, ALU_addi, 1'b1,
             8'h00, 1, 0, 1'b0, 1'b1, 1'b0);
    do_instr(enc(7'h00, 3'd1, 7'h63), T_CND, ALU_sub, 1'b0,
             8'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    do_instr(enc(7'h00, 3'd1, 7'h63), T_CND, ALU_sub, 1'b0,
             8'h00, 0, 0, 1'b1, 1'b1, 1'b0);
    do_instr(enc(7'h00, 3'd0, 7'h63), T_CND, ALU_sub, 1'b0,
             8'h00, 0, 0, 1'b1, 1'b0, 1'b0);
    do_instr(enc(7'h00, 3'd0, 7'h6F), T_JMP, ALU_addi, 1'b1,
             8'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    do_instr(enc(7'h00, 3'd0, 7'h67), T_JMP, ALU_addi, 1'b1,
             8'h00, 0, 0, 1'b0, 1'b1, 1'b0);
    do_instr(enc(7'h00, 3'd3, 7'h03), T_LD, ALU_addi, 1'b1,
             8'h00, 1, 0, 1'b0, 1'b0, 1'b0);
    do_instr(enc(7'h00, 3'd3, 7'h03), T_LD, ALU_addi, 1'b1,
             8'h00, 0, WAIT_MAX, 1'b0, 1'b1, 1'b0);
    do_instr(enc(7'h00, 3'd2, 7'h23), T_ST, ALU_addi, 1'b1,
             8'h0F, 0, 2, 1'b0, 1'b0, 1'b0);
    do_instr(enc(7'h00, 3'd1, 7'h23), T_ST, ALU_addi, 1'b1,
             8'h03, 0, 0, 1'b0, 1'b1, 1'b0);
    do_instr(enc(7'h00, 3'd3, 7'h23), T_ST, ALU_addi, 1'b1,
             8'hFF, 0, 1, 1'b0, 1'b0, 1'b0);
    do_instr(enc(7'h00, 3'd0, 7'h33), T_AR, ALU_add, 1'b0,
             8'h00, WAIT_MAX, 0, 1'b0, 1'b0, 1'b0);
`ifdef STORE_BYTE_EN
    do_instr(enc(7'h00, 3'd0, 7'h23), T_ST, ALU_addi, 1'b1,
             8'h01, 0, 0, 1'b0, 1'b0, 1'b0);
`else
    do_instr(enc(7'h00, 3'd0, 7'h23), T_ILL, 3'd0, 1'b0,
             8'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    do_reset();
`endif
    do_instr(enc(7'h20, 3'd0, 7'h33), T_AR, ALU_sub, 1'b0,
             8'h00, 0, 0, 1'b0, 1'b0, 1'b1);
    do_reset();
    do_instr(enc(7'h02, 3'd0, 7'h13), T_AR, ALU_addi, 1'b1,
             8'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    do_instr(enc(7'h00, 3'd3, 7'h03), T_LD, ALU_addi, 1'b1,
             8'h00, 0, 100, 1'b0, 1'b0, 1'b0);
    do_reset();
    do_instr(enc(7'h00, 3'd0, 7'h7F), T_ILL, 3'd0, 1'b0,
             8'h00, 0, 0, 1'b0, 1'b1, 1'b0);
    do_reset();
    do_instr(enc(7'h00, 3'd0, 7'h33), T_AR, ALU_add, 1'b0,
             8'h00, 100, 0, 1'b0, 1'b0, 1'b0);
    do_reset();
    do_instr(enc(7'h00, 3'd7, 7'h33), T_AR, ALU_and, 1'b0,
             8'h00, 0, 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #6;
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle instruction decoder: a registered state machine that sequences each RV instruction through fetch, decode, execute, memory and write-back. It issues handshakes to instruction and data memory, drives the existing datapath control signals one phase at a time, and traps on illegal instructions or memory timeouts. It sits between the instruction register/PC logic and the ALU, register file and data memory. It is parametrised in data width and memory wait limit.

## Interface
- XLEN, 64, datapath width (32 or 64); store mask width is XLEN/8
- WAIT_MAX, 15, maximum cycles a memory request may remain unacknowledged before trapping (≥1)

- clk  in  1  clock, rising edge
- nrst  in  1  asynchronous active-low reset
- instr  in  32  instruction word from instruction memory, valid with instr_valid
- instr_valid  in  1  instruction memory acknowledge
- mem_ack  in  1  data memory acknowledge
- alu_zero  in  1  ALU zero flag, sampled in EXEC
- imem_req  out  1  instruction fetch request
- ir_wr  out  1  latch instr into the instruction register
- pc_wr  out  1  PC update (sequential, branch or jump target)
- ALUsrc  out  1  ALU operand 2 select: 1 = immediate
- ALUOp  out  3  ALU operation, using the shared ALU_* encodings
- memtoreg  out  2  write-back source: 00 = ALU, 01 = memory, 10 = PC+4
- mem_req  out  1  data memory request
- mem_wr  out  1  data memory write (qualified by mem_req)
- wmask  out  XLEN/8  byte write mask
- bra, bne, jump  out  1 each  branch, not-equal and jump flags for the PC mux
- reg_wr  out  1  register file write enable
- illegal  out  1  sticky trap flag: illegal instruction
- fault  out  1  sticky trap flag: memory timeout
- state  out  3  current state, for debug

## Operation
- States:
  - FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
  - The state register resets to FETCH.
- Outputs are registered Moore outputs, computed from the next state and the latched decode word.
- FETCH:
  - imem_req=1.
  - On instr_valid: ir_wr=1 for one cycle, pc_wr=1 (PC+4), go to DECODE.
- DECODE:
  - Decode opcode/funct3/funct7 into a control word register.
  - Same opcode and ALUOp mapping as the single-cycle decoder: ARITH, ADDI, COND, JAL, JALR, LOAD, STORE.
  - Unknown opcode, an unsupported ARITH funct3, or an unsupported STORE funct3 goes to TRAP with illegal=1.
- EXEC:
  - Drive ALUsrc and ALUOp.
  - COND: bra=1, bne=funct3==BNE; pc_wr=1 only if alu_zero^bne; then go to FETCH.
  - JAL/JALR: jump=1, pc_wr=1, then go to WB.
  - LOAD/STORE: go to MEM.
  - ARITH/ADDI: go to WB.
- MEM:
  - mem_req=1 and ALUOp=ALU_addi are held until mem_ack.
  - STORE: mem_wr=1 and wmask is valid; on ack go to FETCH.
  - LOAD: on ack go to WB.
- WB:
  - reg_wr=1 for exactly one cycle; memtoreg is per opcode (ALU / memory / PC+4).
  - Then go to FETCH.
- Store masks:
  - SD → all ones; with XLEN=32, SD is illegal.
  - SW → low 4 bits set.
  - SH → low 2 bits set.
- TRAP:
  - All enables are 0; illegal/fault hold their values.
  - The block leaves TRAP only on reset.
- Wait counter:
  - Width clog2(WAIT_MAX+1).
  - Counts cycles in FETCH without instr_valid, and cycles in MEM without mem_ack.
  - Clears on every state change.
  - Reaching WAIT_MAX goes to TRAP with fault=1.

## Timing
- Reset:
  - Every output is 0 while nrst is low, including state=0, illegal, fault and wmask.
  - The counter and decode register are cleared.
- imem_req first rises on the first clock edge after nrst deasserts.
- Cycle counts with zero-wait memory, measured from FETCH entry to the next FETCH entry:
  - ARITH/ADDI: 4
  - COND: 3
  - JAL/JALR: 4
  - LOAD: 5
  - STORE: 4
- An acknowledge arriving in the first request cycle is accepted; that state then lasts exactly one cycle.
- instr_valid outside FETCH and mem_ack outside MEM are ignored.
- If an ack and counter==WAIT_MAX occur in the same cycle, the ack wins.
- Asynchronous reset mid-instruction aborts the instruction: no reg_wr or mem_wr is issued afterwards.

## Configuration
- STORE_BYTE_EN:
  - When defined, STORE with funct3=SB is legal and wmask=1 (only bit 0 set).
  - When undefined, SB goes to TRAP with illegal=1.

## Structure
- Shared header def.v holds:
  - the opcode, funct3 and funct7 constants;
  - the ALU_* encodings;
  - the new SB funct3 and the state encodings.
- Sub-module instr_decode: combinational, instr → control word plus illegal bit; it is registered in DECODE.

## Test plan
- ADD (funct7=0x20 gives SUB) with instr_valid in the first cycle → ALUOp=ALU_sub in EXEC; reg_wr for exactly 1 cycle in the 4th cycle; back in FETCH at cycle 5.
- BNE with alu_zero=0 → bra=1, bne=1, pc_wr=1 in EXEC; with alu_zero=1 → pc_wr=0; 3 cycles per instruction.
- SW (XLEN=64) with mem_ack after 3 cycles → mem_req held for 3 cycles, mem_wr=1, wmask=0x0F, reg_wr never 1.
- LD with mem_ack withheld → fault=1 after WAIT_MAX=15 MEM cycles; state=7 held until nrst pulse; all outputs 0 after reset.
- Opcode 0x7F, then SB with/without STORE_BYTE_EN → illegal=1 / wmask=0x01 respectively.
- nrst asserted during WB → reg_wr drops immediately and the next instruction starts with imem_req after release.
